// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit_pkg : shared types and constants for the fetch front end      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fetch_unit_pkg;

   localparam int PC_W = 64;

   typedef enum logic {
      USER       = 1'b0,
      SUPERVISOR = 1'b1
   } priv_level_t;

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2,
      S_HALT    = 2'd3
   } fetch_state_t;

   localparam logic [PC_W-1:0] PRIV_ROUTINE_START = 64'h0000_0000_0000_8000;
   localparam logic [31:0]     NOP_INSN           = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]     insn;
      logic [PC_W-1:0] pc;
      logic            fault;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory request/response handshake            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fetch_unit_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  imem_req_valid;
   logic [DATA_WIDTH-1:0] imem_req_addr;
   logic                  imem_req_ready;
   logic                  imem_resp_valid;
   logic [31:0]           imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_fifo : synchronous FIFO of fetch entries, flush dominates push     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   input  wire logic                   push_i,
   input  wire fetch_entry_t           push_data_i,
   input  wire logic                   pop_i,
   input  wire logic                   flush_i,
   output logic [$clog2(DEPTH):0]      count_o,
   output fetch_entry_t                head_o
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W:0]     count_q;
   logic               push_en;
   logic               pop_en;

   assign push_en = push_i && !flush_i;
   assign pop_en  = pop_i && !flush_i && (count_q != '0);

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_en, pop_en})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rst_n && push_en) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign count_o = count_q;
   assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : single-outstanding fetch front end with redirect flush;     |
// | optional user-mode privilege fetch check via FETCH_PRIV_CHECK_EN. Rev 1.0|
// +--------------------------------------------------------------------------+
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 4
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  redirect_valid_i,
   input  wire logic [DATA_WIDTH-1:0] redirect_pc_i,
   input  wire priv_level_t           cpl_i,
   fetch_unit_if.master               imem,
   output logic                       insn_valid_o,
   output logic [31:0]                insn_o,
   output logic [DATA_WIDTH-1:0]      insn_pc_o,
   output logic                       insn_fault_o,
   input  wire logic                  insn_ready_i
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t          state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
   logic                  started_q;

   logic                  req_valid;
   logic                  push;
   logic                  pop;
   logic                  flush;
   fetch_entry_t          push_entry;
   fetch_entry_t          head;
   logic [CNT_W-1:0]      count;
   logic                  has_slot;
   logic                  priv_fault;

   assign has_slot = (count < CNT_W'(FIFO_DEPTH));

`ifdef FETCH_PRIV_CHECK_EN
   assign priv_fault   = (cpl_i == USER) && (PC_W'(pc_q) >= PRIV_ROUTINE_START);
   assign insn_fault_o = head.fault;
   logic unused_bits;
   assign unused_bits = ^redirect_pc_i[1:0];
`else
   assign priv_fault   = 1'b0;
   assign insn_fault_o = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{cpl_i, head.fault, redirect_pc_i[1:0]};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         req_pc_q  <= '0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_pc_q  <= req_pc_d;
         started_q <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      req_valid  = 1'b0;
      push       = 1'b0;
      push_entry = '0;
      pop        = insn_valid_o && insn_ready_i;
      flush      = 1'b0;

      case (state_q)
         S_REQ: begin
            // A request is only issued when the response already has a slot.
            if (started_q && has_slot) begin
               if (priv_fault) begin
                  push       = 1'b1;
                  push_entry = '{insn: NOP_INSN, pc: PC_W'(pc_q), fault: 1'b1};
                  state_d    = S_HALT;
               end else begin
                  req_valid = 1'b1;
                  if (imem.imem_req_ready) begin
                     pc_d     = pc_q + DATA_WIDTH'(4);
                     req_pc_d = pc_q;
                     state_d  = S_WAIT;
                  end
               end
            end
         end
         S_WAIT: begin
            if (imem.imem_resp_valid) begin
               push       = 1'b1;
               push_entry = '{insn: imem.imem_resp_data, pc: PC_W'(req_pc_q), fault: 1'b0};
               state_d    = S_REQ;
            end
         end
         S_DISCARD: begin
            if (imem.imem_resp_valid) state_d = S_REQ;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_REQ;
         end
      endcase

      // Redirect overrides everything; a request accepted this cycle is stale.
      if (redirect_valid_i) begin
         flush = 1'b1;
         pop   = 1'b0;
         push  = 1'b0;
         pc_d  = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
         case (state_q)
            S_WAIT:    state_d = imem.imem_resp_valid ? S_REQ : S_DISCARD;
            S_DISCARD: state_d = imem.imem_resp_valid ? S_REQ : S_DISCARD;
            S_REQ:     state_d = (req_valid && imem.imem_req_ready) ? S_DISCARD : S_REQ;
            default:   state_d = S_REQ;
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push),
      .push_data_i(push_entry),
      .pop_i      (pop),
      .flush_i    (flush),
      .count_o    (count),
      .head_o     (head)
   );

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = pc_q;
   assign insn_valid_o        = (count != '0);
   assign insn_o              = head.insn;
   assign insn_pc_o           = DATA_WIDTH'(head.pc);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : directed table-driven bench for fetch_unit               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   priv_level_t cpl;
   logic        insn_valid;
   logic [31:0] insn;
   logic [63:0] insn_pc;
   logic        insn_fault;
   logic        insn_ready;

   int checks = 0;
   int errors = 0;
   int mem_lat = 1;
   int pend_cnt = 0;
   logic [63:0] pend_addr = '0;

   fetch_unit_if #(.DATA_WIDTH(64)) ifc ();

   fetch_unit #(
      .DATA_WIDTH(64),
      .RESET_PC  (64'h0),
      .FIFO_DEPTH(4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .redirect_valid_i(redirect_valid),
      .redirect_pc_i   (redirect_pc),
      .cpl_i           (cpl),
      .imem            (ifc),
      .insn_valid_o    (insn_valid),
      .insn_o          (insn),
      .insn_pc_o       (insn_pc),
      .insn_fault_o    (insn_fault),
      .insn_ready_i    (insn_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(logic [63:0] a);
      return 32'hC0DE_0000 | {16'h0, a[15:0]};
   endfunction

   // Memory model: answers each accepted request mem_lat cycles later.
   initial begin
      ifc.imem_resp_valid = 1'b0;
      ifc.imem_resp_data  = '0;
      forever begin
         @(posedge clk);
         if (ifc.imem_req_valid && ifc.imem_req_ready) begin
            pend_addr = ifc.imem_req_addr;
            pend_cnt  = mem_lat;
         end
         #1;
         ifc.imem_resp_valid = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               ifc.imem_resp_valid = 1'b1;
               ifc.imem_resp_data  = mem_word(pend_addr);
            end
         end
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic chk_out(string tag, bit erv, logic [63:0] ea, bit eiv,
                          logic [63:0] epc, logic [31:0] einsn, bit efault);
      chk({tag, ".req_valid"}, 64'(ifc.imem_req_valid), 64'(erv));
      if (erv) chk({tag, ".req_addr"}, ifc.imem_req_addr, ea);
      chk({tag, ".insn_valid"}, 64'(insn_valid), 64'(eiv));
      if (eiv) begin
         chk({tag, ".insn_pc"}, insn_pc, epc);
         chk({tag, ".insn"}, 64'(insn), 64'(einsn));
         chk({tag, ".fault"}, 64'(insn_fault), 64'(efault));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   typedef struct packed {
      bit          rdy;
      bit          ird;
      bit          erv;
      logic [63:0] ea;
      bit          eiv;
      logic [63:0] epc;
   } vec_t;

   vec_t tbl [20];

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 64'h4,  1'b1, 64'h0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 64'h8,  1'b1, 64'h4};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 64'h8,  1'b0, 64'h0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 64'hC,  1'b1, 64'h8};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 64'h8};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 64'h10, 1'b1, 64'h8};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 64'h8};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 64'h14, 1'b1, 64'h8};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 64'h8};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 64'h8};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 64'h8};
      tbl[15] = '{1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h8};
      tbl[16] = '{1'b1, 1'b0, 1'b1, 64'h18, 1'b1, 64'hC};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 64'hC};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 64'hC};
      tbl[19] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 64'hC};

      rst_n              = 1'b0;
      redirect_valid     = 1'b0;
      redirect_pc        = '0;
      cpl                = SUPERVISOR;
      insn_ready         = 1'b1;
      ifc.imem_req_ready = 1'b1;

      repeat (3) @(posedge clk);
      sample();
      chk("reset.req_valid", 64'(ifc.imem_req_valid), 64'h0);
      chk("reset.insn_valid", 64'(insn_valid), 64'h0);
      chk("reset.insn", 64'(insn), 64'h0);
      chk("reset.insn_pc", insn_pc, 64'h0);
      chk("reset.fault", 64'(insn_fault), 64'h0);

      step(); rst_n = 1'b1; sample();
      chk_out("release", 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 20; i++) begin
         step();
         ifc.imem_req_ready = tbl[i].rdy;
         insn_ready         = tbl[i].ird;
         sample();
         chk_out($sformatf("vec%0d", i), tbl[i].erv, tbl[i].ea, tbl[i].eiv,
                 tbl[i].epc, mem_word(tbl[i].epc), 1'b0);
      end

      // Redirect while a request is outstanding; the late response is stale.
      step(); insn_ready = 1'b1; mem_lat = 2; sample();
      chk_out("drain", 0, 0, 1, 64'hC, mem_word(64'hC), 0);
      step(); insn_ready = 1'b0; sample();
      chk_out("wait_req", 1, 64'h1C, 1, 64'h10, mem_word(64'h10), 0);
      step(); redirect_valid = 1'b1; redirect_pc = 64'h1002; sample();
      chk_out("redir_wait", 0, 0, 1, 64'h10, mem_word(64'h10), 0);
      step(); redirect_valid = 1'b0; mem_lat = 1; sample();
      chk_out("redir_r1", 0, 0, 0, 0, 0, 0);
      step(); sample();
      chk_out("redir_new", 1, 64'h1000, 0, 0, 0, 0);
      step(); insn_ready = 1'b1; sample();
      chk_out("redir_wait2", 0, 0, 0, 0, 0, 0);

      // Redirect in the same cycle as a request handshake.
      step(); redirect_valid = 1'b1; redirect_pc = 64'h200; sample();
      chk_out("redir_first", 1, 64'h1004, 1, 64'h1000, mem_word(64'h1000), 0);
      step(); redirect_valid = 1'b0; sample();
      chk_out("hs_redir_r1", 0, 0, 0, 0, 0, 0);
      step(); sample();
      chk_out("hs_redir_req", 1, 64'h200, 0, 0, 0, 0);
      step(); sample();
      chk_out("hs_redir_wait", 0, 0, 0, 0, 0, 0);

      // Redirect to the top word: low bits forced to zero, PC wraps.
      step(); redirect_valid = 1'b1; redirect_pc = '1; ifc.imem_req_ready = 1'b0; sample();
      chk_out("hs_redir_first", 1, 64'h204, 1, 64'h200, mem_word(64'h200), 0);
      step(); redirect_valid = 1'b0; ifc.imem_req_ready = 1'b1; sample();
      chk_out("wrap_req", 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
      step(); mem_lat = 3; sample();
      chk_out("wrap_wait", 0, 0, 0, 0, 0, 0);
      step(); sample();
      chk_out("wrap_next", 1, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC,
              mem_word(64'hFFFF_FFFF_FFFF_FFFC), 0);

      // Reset with a request outstanding; its response lands after release.
      step(); rst_n = 1'b0; sample();
      chk_out("rst_wait", 0, 0, 0, 0, 0, 0);
      step(); sample();
      chk_out("rst_hold", 0, 0, 0, 0, 0, 0);
      chk("rst_hold.insn_pc", insn_pc, 64'h0);
      step(); rst_n = 1'b1; mem_lat = 1; sample();
      chk_out("rst_release", 0, 0, 0, 0, 0, 0);
      step(); sample();
      chk_out("rst_restart", 1, 64'h0, 0, 0, 0, 0);
      step(); sample();
      chk_out("rst_wait2", 0, 0, 0, 0, 0, 0);
      step(); ifc.imem_req_ready = 1'b0; sample();
      chk_out("rst_first", 1, 64'h4, 1, 64'h0, mem_word(64'h0), 0);

      // User-mode fetch of the privileged routine region.
      step(); redirect_valid = 1'b1; redirect_pc = 64'h8000; cpl = USER; sample();
      chk_out("priv_redir", 1, 64'h4, 0, 0, 0, 0);
      step(); redirect_valid = 1'b0; sample();
`ifdef FETCH_PRIV_CHECK_EN
      chk_out("priv_enter", 0, 0, 0, 0, 0, 0);
      step(); sample();
      chk_out("priv_entry", 0, 0, 1, 64'h8000, NOP_INSN, 1);
      step(); sample();
      chk_out("priv_halt", 0, 0, 0, 0, 0, 0);
      step(); redirect_valid = 1'b1; redirect_pc = 64'h8000; cpl = SUPERVISOR; sample();
      chk_out("priv_halt2", 0, 0, 0, 0, 0, 0);
      step(); redirect_valid = 1'b0; sample();
      chk_out("priv_sup", 1, 64'h8000, 0, 0, 0, 0);
`else
      chk_out("nopriv_fetch", 1, 64'h8000, 0, 0, 0, 0);
      step(); sample();
      chk_out("nopriv_hold", 1, 64'h8000, 0, 0, 0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end, the consumer of the branch unit's next-PC redirect. Holds the architectural fetch PC, issues one-at-a-time word requests to instruction memory over a valid/ready handshake, buffers returned instructions with their PCs in a small FIFO for decode, and on a retired redirect flushes buffered and in-flight fetches and restarts at the new PC.

## Interface
- DATA_WIDTH, 64, address/PC width
- RESET_PC, 0, first fetch address after reset
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- redirect_valid_i  in  1  retired branch/jump/ECALL/ERET redirect
- redirect_pc_i  in  DATA_WIDTH  redirect target; bits [1:0] ignored (forced 0)
- cpl_i  in  priv_level_t  current privilege (USER/SUPERVISOR)
- imem_req_valid_o  out  1  fetch request
- imem_req_addr_o  out  DATA_WIDTH  word-aligned fetch address
- imem_req_ready_i  in  1  memory accepts request
- imem_resp_valid_i  in  1  response for the single outstanding request
- imem_resp_data_i  in  32  instruction word
- insn_valid_o  out  1  FIFO head valid
- insn_o  out  32  head instruction
- insn_pc_o  out  DATA_WIDTH  head PC
- insn_fault_o  out  1  head is a privilege fetch fault
- insn_ready_i  in  1  decode pops head when insn_valid_o & insn_ready_i

## Operation
- States: REQ (request driven), WAIT (one request outstanding), DISCARD (outstanding response is stale), HALT (fault pushed, stopped).
- REQ: imem_req_valid_o=1 only when FIFO count < FIFO_DEPTH (slot reserved for the response); addr=pc. On valid&ready: pc<=pc+4 (wraps modulo 2^DATA_WIDTH), ->WAIT.
- WAIT: on imem_resp_valid_i push {data, pc_of_req, 0}, ->REQ. Responses outside WAIT/DISCARD are ignored.
- Redirect (highest priority, any state): FIFO emptied, pop that cycle discarded, pc<=redirect_pc_i&~3. From WAIT ->DISCARD; from WAIT with response in the same cycle, response dropped, ->REQ; from REQ/HALT/DISCARD ->REQ, except DISCARD with no response yet stays DISCARD. Redirect during a REQ handshake cancels that acceptance: pc takes redirect target, state DISCARD (accepted request is stale).
- DISCARD: response dropped, ->REQ.
- imem_req_addr_o changes while valid is high only on redirect.
- Simultaneous push and pop: both occur, count unchanged; pop on empty never occurs (valid low).

## Timing
- Reset values: imem_req_valid_o=0, insn_valid_o=0, insn_fault_o=0, insn_o=0, insn_pc_o=0, pc=RESET_PC, state REQ, FIFO empty. Reset mid-transaction drops the outstanding response.
- First request: cycle after rst_n rises.
- Request accepted cycle N -> response earliest N+1 -> insn_valid_o earliest N+2 (registered FIFO).
- Redirect cycle R -> insn_valid_o=0 at R+1; if no stale response pending, imem_req_valid_o=1 with new address at R+1.
- Throughput: one instruction per two cycles minimum (single outstanding).

## Configuration
- FETCH_PRIV_CHECK_EN defined: in REQ, if cpl_i==USER and pc >= PRIV_ROUTINE_START, no memory request; push {NOP_INSN, pc, 1} and enter HALT until redirect. Entered only when a FIFO slot is free.
- Undefined: no check, such addresses fetched normally; insn_fault_o tied 0.

## Structure
- Shared package: priv_level_t {USER, SUPERVISOR}, PRIV_ROUTINE_START, NOP_INSN (32'h0000_0013), fetch_entry_t {insn, pc, fault}.
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with push, pop, flush (flush dominates push), count, head output.

## Test plan
- Reset, memory ready always, 1-cycle response, insn_ready_i=1 -> requests 0x0,0x4,0x8…; insn_pc_o increments by 4, insn_o matches memory.
- insn_ready_i=0 with FIFO_DEPTH=4 -> exactly 4 entries then imem_req_valid_o=0; one pop -> exactly one new request.
- Redirect to 0x1002 while WAIT, response 2 cycles later -> response dropped, next request addr 0x1000, first delivered insn_pc_o=0x1000.
- Redirect same cycle as request handshake to 0x200 -> that response discarded, next request 0x200; FIFO flushed at R+1.
- FETCH_PRIV_CHECK_EN, cpl_i=USER, redirect to PRIV_ROUTINE_START -> no request, one entry insn_o=0x13, insn_fault_o=1, then idle; SUPERVISOR -> normal fetch.
- rst_n low while request outstanding, late response arrives -> ignored; fetch restarts at RESET_PC.
